color_threshold_cfg_seq: RTL and testbench

COLOR_THRESHOLD_CFG_SEQ -- requirements
Module: color_threshold_cfg_seq

---
 rtl/color_threshold_cfg_seq_pkg.sv | 28 ++
 rtl/color_threshold_cfg_seq_if.sv | 34 +++
 rtl/color_threshold_cfg_seq_timeout.sv | 30 +++
 rtl/color_threshold_cfg_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_color_threshold_cfg_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_threshold_cfg_seq_pkg.sv
// color_threshold_pkg: shared types and constants for the color_threshold
// configuration sequencer.
//   - ct_state_e       : sequencer state encoding
//   - AXI_RESP_*       : AXI response codes
//   - CT_REG_STRIDE    : byte distance between consecutive registers
//   - ct_reg_addr()    : register index -> byte address
// Optional feature macro: CT_CFG_READBACK_EN (see color_threshold_cfg_seq.sv).
package color_threshold_pkg;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
   localparam int unsigned CT_REG_STRIDE   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WRESP,
      ST_RD,
      ST_RDATA,
      ST_NEXT,
      ST_FIN
   } ct_state_e;

   function automatic logic [31:0] ct_reg_addr(input logic [31:0] base, input logic [3:0] idx);
      return base + (32'(idx) * CT_REG_STRIDE);
   endfunction

endpackage

// File: rtl/color_threshold_cfg_seq_if.sv
// color_threshold_cfg_seq_if: AXI4-Lite bus between the configuration
// sequencer (master) and the color_threshold register bank (slave).
//   AW: awaddr/awvalid/awready      W: wdata/wstrb/wvalid/wready
//   B : bresp/bvalid/bready         AR: araddr/arvalid/arready
//   R : rdata/rresp/rvalid/rready
interface color_threshold_cfg_seq_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/color_threshold_cfg_seq_timeout.sv
// ct_cfg_timeout: loadable down-counter used as a per-state handshake timer.
//   ACLK, ARESETN : clock, synchronous active-low reset
//   load          : reload counter with load_val (held off expiry this cycle)
//   load_val      : reload value
//   expired       : counter has reached zero since the last load
module ct_cfg_timeout #(
   parameter int unsigned W = 8
) (
   input  logic         ACLK,
   input  logic         ARESETN,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = !load && (cnt == '0);

endmodule

// File: rtl/color_threshold_cfg_seq.sv
// color_threshold_cfg_seq: programs C_NUM_REGS registers of the color_threshold
// bank over AXI4-Lite, one write at a time, and flags the first failure.
//   ACLK, ARESETN : clock, synchronous active-low reset
//   start         : one-cycle request (ignored while busy)
//   cfg_data      : register values, slice i -> register i, captured at start
//   busy, done    : sequence running / one-cycle end pulse
//   error         : sticky failure flag, err_index = register that failed
//   m_axi         : AXI4-Lite master port
// Macro CT_CFG_READBACK_EN: read each register back after writing it and
// compare; without it the read channel is tied off.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start
// ST_WR    | AW and W in flight, each drops after its handshake
// ST_WRESP | waiting for write response
// ST_RD    | read address in flight (readback builds only)
// ST_RDATA | waiting for read data, compare (readback builds only)
// ST_NEXT  | advance index or finish
// ST_FIN   | done pulse, back to idle
module color_threshold_cfg_seq
   import color_threshold_pkg::*;
#(
   parameter logic [31:0] C_BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned C_NUM_REGS    = 4,
   parameter int unsigned C_TIMEOUT_CYC = 255
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic                        start,
   input  logic [32*C_NUM_REGS-1:0]    cfg_data,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [3:0]                  err_index,
   color_threshold_cfg_seq_if.master   m_axi
);

   localparam int unsigned      TMO_W    = (C_TIMEOUT_CYC < 2) ? 1 : $clog2(C_TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(C_TIMEOUT_CYC);
   localparam logic [3:0]       LAST_IDX = 4'(C_NUM_REGS - 1);

   ct_state_e                     state;
   logic [3:0]                    index;
   logic [32*C_NUM_REGS-1:0]      cfg_q;
   logic [32*C_NUM_REGS-1:0]      cfg_shift;
   logic                          aw_done, w_done;
   logic                          aw_hs, w_hs, wr_complete;
   logic                          tmo_load, tmo_expired;
   logic                          fail_now;

   // The register being written is always in cfg_q[31:0]; advancing shifts.
   assign cfg_shift   = cfg_q >> 32;
   assign aw_hs       = m_axi.awvalid && m_axi.awready;
   assign w_hs        = m_axi.wvalid && m_axi.wready;
   assign wr_complete = (aw_done || aw_hs) && (w_done || w_hs);
   assign m_axi.wstrb = 4'hF;

`ifdef CT_CFG_READBACK_EN
   logic ar_hs;
   assign ar_hs = m_axi.arvalid && m_axi.arready;
`else
   assign m_axi.araddr  = '0;
   assign m_axi.arvalid = 1'b0;
   assign m_axi.rready  = 1'b0;
`endif

   always_comb begin
      fail_now = 1'b0;
      case (state)
         ST_WR:    fail_now = !wr_complete && tmo_expired;
         ST_WRESP: fail_now = m_axi.bvalid ? (m_axi.bresp != AXI_RESP_OKAY) : tmo_expired;
`ifdef CT_CFG_READBACK_EN
         ST_RD:    fail_now = !ar_hs && tmo_expired;
         ST_RDATA: fail_now = m_axi.rvalid ? ((m_axi.rresp != AXI_RESP_OKAY) ||
                                              (m_axi.rdata != m_axi.wdata))
                                           : tmo_expired;
`endif
         default:  fail_now = 1'b0;
      endcase
   end

   ct_cfg_timeout #(.W(TMO_W)) u_timeout (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .load     (tmo_load),
      .load_val (TMO_LOAD),
      .expired  (tmo_expired)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state         <= ST_IDLE;
         index         <= '0;
         cfg_q         <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         tmo_load      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_index     <= '0;
         m_axi.awaddr  <= '0;
         m_axi.awvalid <= 1'b0;
         m_axi.wdata   <= '0;
         m_axi.wvalid  <= 1'b0;
         m_axi.bready  <= 1'b0;
`ifdef CT_CFG_READBACK_EN
         m_axi.araddr  <= '0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready  <= 1'b0;
`endif
      end else begin
         tmo_load <= 1'b0;
         done     <= 1'b0;
         if (fail_now) begin
            // Abort: drop every valid/ready and report the current register.
            error         <= 1'b1;
            err_index     <= index;
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
`ifdef CT_CFG_READBACK_EN
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
`endif
            done          <= 1'b1;
            tmo_load      <= 1'b1;
            state         <= ST_FIN;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     cfg_q         <= cfg_data;
                     index         <= '0;
                     error         <= 1'b0;
                     err_index     <= '0;
                     busy          <= 1'b1;
                     m_axi.awaddr  <= ct_reg_addr(C_BASE_ADDR, 4'd0);
                     m_axi.wdata   <= cfg_data[31:0];
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                     tmo_load      <= 1'b1;
                     state         <= ST_WR;
                  end
               end
               ST_WR: begin
                  if (aw_hs) begin
                     m_axi.awvalid <= 1'b0;
                     aw_done       <= 1'b1;
                  end
                  if (w_hs) begin
                     m_axi.wvalid <= 1'b0;
                     w_done       <= 1'b1;
                  end
                  if (wr_complete) begin
                     m_axi.bready <= 1'b1;
                     tmo_load     <= 1'b1;
                     state        <= ST_WRESP;
                  end
               end
               ST_WRESP: begin
                  if (m_axi.bvalid) begin
                     m_axi.bready <= 1'b0;
                     tmo_load     <= 1'b1;
`ifdef CT_CFG_READBACK_EN
                     m_axi.araddr  <= m_axi.awaddr;
                     m_axi.arvalid <= 1'b1;
                     state         <= ST_RD;
`else
                     state         <= ST_NEXT;
`endif
                  end
               end
`ifdef CT_CFG_READBACK_EN
               ST_RD: begin
                  if (ar_hs) begin
                     m_axi.arvalid <= 1'b0;
                     m_axi.rready  <= 1'b1;
                     tmo_load      <= 1'b1;
                     state         <= ST_RDATA;
                  end
               end
               ST_RDATA: begin
                  if (m_axi.rvalid) begin
                     m_axi.rready <= 1'b0;
                     tmo_load     <= 1'b1;
                     state        <= ST_NEXT;
                  end
               end
`endif
               ST_NEXT: begin
                  tmo_load <= 1'b1;
                  if (index == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= ST_FIN;
                  end else begin
                     index         <= index + 4'd1;
                     cfg_q         <= cfg_shift;
                     m_axi.awaddr  <= ct_reg_addr(C_BASE_ADDR, index + 4'd1);
                     m_axi.wdata   <= cfg_shift[31:0];
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                     state         <= ST_WR;
                  end
               end
               ST_FIN: begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_color_threshold_cfg_seq.sv
// tb_color_threshold_cfg_seq: bench for color_threshold_cfg_seq. A small AXI
// slave with configurable ready delays and fault injection sits on the bus;
// each sequence is compared with the expected write list, error flag and
// failing index derived from the injected faults.
// Honours CT_CFG_READBACK_EN the same way as the design.
module tb_color_threshold_cfg_seq;
   import color_threshold_pkg::*;

   localparam logic [31:0] BASE  = 32'h4000_1000;
   localparam int          N     = 4;
   localparam int          T     = 255;
   localparam int          LIMIT = T + N * 20 + 20;

   logic               tb_ACLK = 1'b0;
   logic               ARESETN = 1'b0;
   logic               start   = 1'b0;
   logic [32*N-1:0]    cfg_data = '0;
   logic               busy, done, error;
   logic [3:0]         err_index;

   color_threshold_cfg_seq_if axi_if ();

   color_threshold_cfg_seq #(
      .C_BASE_ADDR   (BASE),
      .C_NUM_REGS    (N),
      .C_TIMEOUT_CYC (T)
   ) dut (
      .ACLK      (tb_ACLK),
      .ARESETN   (ARESETN),
      .start     (start),
      .cfg_data  (cfg_data),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_index (err_index),
      .m_axi     (axi_if)
   );

   always #5 tb_ACLK = ~tb_ACLK;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // slave configuration
   int aw_delay = 0, w_delay = 0, slverr_idx = -1, bad_rd_idx = -1;
   bit aw_hang = 1'b0;
   int b_base = 0, r_base = 0, w_base = 0;

   // bus monitor
   logic [31:0] aw_q[$];
   logic [31:0] w_q[$];
   int          aw_hi_q[$];
   int          w_hi_q[$];
   int          aw_hi = 0, w_hi = 0, b_cnt = 0, r_cnt = 0, done_cnt = 0;
   logic        b_hs_q = 1'b0, r_hs_q = 1'b0;

   always @(posedge tb_ACLK) begin
      b_hs_q <= axi_if.bvalid && axi_if.bready;
      r_hs_q <= axi_if.rvalid && axi_if.rready;
      if (axi_if.awvalid && axi_if.awready) begin
         aw_q.push_back(axi_if.awaddr);
         aw_hi_q.push_back(aw_hi + 1);
         aw_hi <= 0;
      end else if (axi_if.awvalid) aw_hi <= aw_hi + 1;
      else aw_hi <= 0;
      if (axi_if.wvalid && axi_if.wready) begin
         w_q.push_back(axi_if.wdata);
         w_hi_q.push_back(w_hi + 1);
         w_hi <= 0;
      end else if (axi_if.wvalid) w_hi <= w_hi + 1;
      else w_hi <= 0;
      if (axi_if.bvalid && axi_if.bready) b_cnt <= b_cnt + 1;
      if (axi_if.rvalid && axi_if.rready) r_cnt <= r_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   // slave driver, updates on the falling edge
   int aw_cnt = 0, w_cnt = 0;
   initial begin
      axi_if.awready = 1'b0;
      axi_if.wready  = 1'b0;
      axi_if.bvalid  = 1'b0;
      axi_if.bresp   = AXI_RESP_OKAY;
      axi_if.arready = 1'b0;
      axi_if.rvalid  = 1'b0;
      axi_if.rdata   = '0;
      axi_if.rresp   = AXI_RESP_OKAY;
      forever begin
         @(negedge tb_ACLK);
         if (!axi_if.awvalid) begin
            axi_if.awready = 1'b0;
            aw_cnt = 0;
         end else if (!aw_hang && aw_cnt >= aw_delay) axi_if.awready = 1'b1;
         else begin
            axi_if.awready = 1'b0;
            aw_cnt++;
         end
         if (!axi_if.wvalid) begin
            axi_if.wready = 1'b0;
            w_cnt = 0;
         end else if (w_cnt >= w_delay) axi_if.wready = 1'b1;
         else begin
            axi_if.wready = 1'b0;
            w_cnt++;
         end
         if (b_hs_q) axi_if.bvalid = 1'b0;
         else if (axi_if.bready && !axi_if.bvalid) begin
            axi_if.bvalid = 1'b1;
            axi_if.bresp  = ((b_cnt - b_base) == slverr_idx) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
         axi_if.arready = axi_if.arvalid;
         if (r_hs_q) axi_if.rvalid = 1'b0;
         else if (axi_if.rready && !axi_if.rvalid) begin
            int k;
            k = w_base + (r_cnt - r_base);
            axi_if.rvalid = 1'b1;
            axi_if.rresp  = AXI_RESP_OKAY;
            axi_if.rdata  = (k < w_q.size()) ? w_q[k] : 32'h0;
            if ((r_cnt - r_base) == bad_rd_idx) axi_if.rdata = axi_if.rdata ^ 32'h1;
         end
      end
   end

   function automatic logic [31:0] slice(input logic [32*N-1:0] v, input int i);
      return 32'(v >> (32 * i));
   endfunction

   function automatic logic [32*N-1:0] rand_cfg();
      logic [32*N-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = (c << 32) | (32*N)'($urandom);
      return c;
   endfunction

   task automatic run_seq(input string tag, input logic [32*N-1:0] cfg, input int awd, input int wd,
                          input int slv_idx, input int rd_idx, input bit hang);
      int aw0, w0, done0, exp_fail, exp_aw, exp_w, cyc, n;
      bit seen;
      aw0 = aw_q.size();
      w0 = w_q.size();
      done0 = done_cnt;
      aw_delay = awd;
      w_delay = wd;
      slverr_idx = slv_idx;
      bad_rd_idx = rd_idx;
      aw_hang = hang;
      b_base = b_cnt;
      r_base = r_cnt;
      w_base = w_q.size();
      // reference: first register whose write response or readback fails
      exp_fail = -1;
      if (hang) exp_fail = 0;
      else begin
         for (int i = 0; i < N; i++) begin
            if (i == slv_idx) begin exp_fail = i; break; end
`ifdef CT_CFG_READBACK_EN
            if (i == rd_idx) begin exp_fail = i; break; end
`endif
         end
      end
      exp_aw = hang ? 0 : ((exp_fail < 0) ? N : exp_fail + 1);
      exp_w  = hang ? 1 : exp_aw;

      @(negedge tb_ACLK);
      cfg_data = cfg;
      start = 1'b1;
      @(negedge tb_ACLK);
      start = 1'b0;
      cfg_data = ~cfg;
      cyc = 1;
      check_val({tag, "_busy"}, 64'(busy), 64'd1);
      start = 1'b1;   // must be ignored while busy
      @(negedge tb_ACLK);
      start = 1'b0;
      cyc = 2;
      seen = 1'b0;
      while (!seen && cyc < LIMIT) begin
         if (done) seen = 1'b1;
         else begin
            @(negedge tb_ACLK);
            cyc++;
         end
      end
      check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (hang) check_val({tag, "_tmo_window"}, 64'((cyc >= T) && (cyc <= T + 3)), 64'd1);
      repeat (3) @(negedge tb_ACLK);
      check_val({tag, "_done_pulses"}, 64'(done_cnt - done0), 64'd1);
      check_val({tag, "_error"}, 64'(error), 64'(exp_fail >= 0));
      check_val({tag, "_err_index"}, 64'(err_index), 64'((exp_fail >= 0) ? exp_fail : 0));
      check_val({tag, "_aw_count"}, 64'(aw_q.size() - aw0), 64'(exp_aw));
      check_val({tag, "_w_count"}, 64'(w_q.size() - w0), 64'(exp_w));
      n = aw_q.size() - aw0;
      for (int i = 0; i < exp_aw && i < n; i++) begin
         check_val($sformatf("%s_awaddr%0d", tag, i), 64'(aw_q[aw0 + i]), 64'(BASE + 32'(4 * i)));
         check_val($sformatf("%s_aw_hi%0d", tag, i), 64'(aw_hi_q[aw0 + i]), 64'(awd + 1));
      end
      n = w_q.size() - w0;
      for (int i = 0; i < exp_w && i < n; i++) begin
         check_val($sformatf("%s_wdata%0d", tag, i), 64'(w_q[w0 + i]), 64'(slice(cfg, i)));
         check_val($sformatf("%s_w_hi%0d", tag, i), 64'(w_hi_q[w0 + i]), 64'(wd + 1));
      end
      check_val({tag, "_idle_outs"},
                64'({busy, axi_if.awvalid, axi_if.wvalid, axi_if.bready, axi_if.arvalid, axi_if.rready}),
                64'd0);
   endtask

   task automatic reset_mid_wr();
      aw_hang = 1'b1;
      w_delay = 0;
      @(negedge tb_ACLK);
      cfg_data = rand_cfg();
      start = 1'b1;
      @(negedge tb_ACLK);
      start = 1'b0;
      repeat (4) @(negedge tb_ACLK);
      check_val("mrst_in_wr", 64'({busy, axi_if.awvalid}), 64'b11);
      ARESETN = 1'b0;
      @(negedge tb_ACLK);
      check_val("mrst_outs",
                64'({busy, done, error, err_index, axi_if.awvalid, axi_if.wvalid,
                     axi_if.bready, axi_if.arvalid, axi_if.rready}), 64'd0);
      check_val("mrst_awaddr", 64'(axi_if.awaddr), 64'd0);
      ARESETN = 1'b1;
      aw_hang = 1'b0;
      repeat (2) @(negedge tb_ACLK);
   endtask

   initial begin
      logic [32*N-1:0] vec037;
      int              awd, wd, slv, rd;
      vec037 = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101ffff};

      ARESETN = 1'b0;
      repeat (3) @(negedge tb_ACLK);
      check_val("rst_outs",
                64'({busy, done, error, err_index, axi_if.awvalid, axi_if.wvalid,
                     axi_if.bready, axi_if.arvalid, axi_if.rready}), 64'd0);
      check_val("rst_wstrb", 64'(axi_if.wstrb), 64'hF);
      check_val("rst_addr", 64'({axi_if.awaddr, axi_if.araddr}), 64'd0);
      ARESETN = 1'b1;
      @(negedge tb_ACLK);

      run_seq("basic", vec037, 0, 0, -1, -1, 1'b0);
      run_seq("awdly", rand_cfg(), 3, 0, -1, -1, 1'b0);
      run_seq("slverr", rand_cfg(), 0, 0, 1, -1, 1'b0);
      run_seq("hang", rand_cfg(), 0, 0, -1, -1, 1'b1);
`ifdef CT_CFG_READBACK_EN
      run_seq("rdbad", vec037, 0, 0, -1, 1, 1'b0);
`endif
      reset_mid_wr();
      run_seq("post_rst", rand_cfg(), 1, 2, -1, -1, 1'b0);

      for (int r = 0; r < 8; r++) begin
         awd = $urandom_range(0, 3);
         wd  = $urandom_range(0, 3);
         slv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1;
`ifdef CT_CFG_READBACK_EN
         rd  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1;
`else
         rd  = -1;
`endif
         run_seq($sformatf("rnd%0d", r), rand_cfg(), awd, wd, slv, rd, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
